// File: rtl/pipe_adder_pkg.sv
// Shared datapath definitions: add/sub op encoding and the signed-overflow rule.
package pipe_adder_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Two's-complement overflow: like-signed operands producing an opposite-signed result.
   function automatic logic adder_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// One SEG-bit segment of the pipelined adder: registered sum and carry, 1-cycle latency.
// Holds its result while en_i is low (pipeline-wide stall).
module adder_slice #(
   parameter int unsigned SEG = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           en_i,
   input  logic [SEG-1:0] a_i,
   input  logic [SEG-1:0] b_i,
   input  logic           ci_i,
   output logic [SEG-1:0] s_o,
   output logic           co_o
);

   logic [SEG-1:0] s_q, s_d;
   logic           co_q, co_d;

   always_comb begin
      {co_d, s_d} = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, ci_i};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s_q  <= '0;
         co_q <= 1'b0;
      end else if (en_i) begin
         s_q  <= s_d;
         co_q <= co_d;
      end
   end

   assign s_o  = s_q;
   assign co_o = co_q;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/sub split into STAGES carry-rippled segments; result after STAGES+1 edges.
// Single global advance (adv = !out_valid || out_ready): a stalled output freezes every stage.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int unsigned SEG = WIDTH / STAGES;

   if (WIDTH % STAGES != 0) begin : g_bad_split
      $error("pipe_adder: WIDTH must be divisible by STAGES");
   end

   logic                           adv;
   logic [WIDTH-1:0]               b_eff;
   logic                           cin_eff;
   logic [STAGES-1:0]              vld_q, vld_d;
   logic [STAGES-1:0]              ci;
   logic [STAGES-1:0]              seg_co;
   logic [STAGES-1:0][SEG-1:0]     seg_s;
   logic [STAGES-1:0][WIDTH-1:0]   a_q, a_d, b_q, b_d, fin_q, fin_d, asm;

   logic             out_valid_q, cout_q, ovf_q, zero_q;
   logic [WIDTH-1:0] sum_q;
   logic             unused_skew;

   assign adv      = !out_valid_q || out_ready;
   assign in_ready = adv;
   assign b_eff    = (op == OP_SUB) ? ~b : b;
   assign cin_eff  = (op == OP_SUB) ? 1'b1 : cin;

   // Stage k adds segment k; operands skew forward, finished low segments accumulate in fin.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign vld_d[k] = in_valid;
         assign a_d[k]   = a;
         assign b_d[k]   = b_eff;
         assign fin_d[k] = '0;
         assign ci[k]    = cin_eff;
      end else begin : g_tail
         assign vld_d[k] = vld_q[k-1];
         assign a_d[k]   = a_q[k-1];
         assign b_d[k]   = b_q[k-1];
         assign fin_d[k] = asm[k-1];
         assign ci[k]    = seg_co[k-1];
      end

      adder_slice #(.SEG(SEG)) u_slice (
         .clk   (clk),
         .reset (reset),
         .en_i  (adv),
         .a_i   (a_d[k][k*SEG +: SEG]),
         .b_i   (b_d[k][k*SEG +: SEG]),
         .ci_i  (ci[k]),
         .s_o   (seg_s[k]),
         .co_o  (seg_co[k])
      );

      assign asm[k] = fin_q[k] | (WIDTH'(seg_s[k]) << (k*SEG));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= '0;
      end else if (adv) begin
         vld_q <= vld_d;
      end
   end

   // Data qualified by vld_q, so no reset needed here.
   always_ff @(posedge clk) begin
      if (adv) begin
         a_q   <= a_d;
         b_q   <= b_d;
         fin_q <= fin_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
      end else if (adv) begin
         out_valid_q <= vld_q[STAGES-1];
         if (vld_q[STAGES-1]) begin
            sum_q  <= asm[STAGES-1];
            cout_q <= seg_co[STAGES-1];
            ovf_q  <= adder_ovf(a_q[STAGES-1][WIDTH-1], b_q[STAGES-1][WIDTH-1],
                                asm[STAGES-1][WIDTH-1]);
            zero_q <= (asm[STAGES-1] == '0);
         end
      end
   end

   // Only the sign bits of the last skew stage feed the flags.
   assign unused_skew = ^{a_q[STAGES-1], b_q[STAGES-1]};

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule
